instr_fetch_prefetch: RTL and testbench
=======================================

// Module: instr_fetch_prefetch
// PURPOSE
//   Fetch stage between the processor decode stage and the two-bank cascaded instruction SPRAM.
//   Generates sequential word fetches, absorbs the SPRAM's 1-cycle read latency and buffers
//   returned instructions in a small FIFO with a valid/ready handshake toward decode.
//   Flushes on branch/jump redirect. Drops the SPRAM into standby after a sustained stall.
// PARAMETERS
//   DEPTH       4      prefetch FIFO entries; power of 2, >= 2
//   RESET_PC    32'h0  byte address fetched first after reset
//   IDLE_LIMIT  16     consecutive no-issue cycles in RUN before mem_standby asserts; >= 1
// PORTS
//   clk             in   1   single clock; all state on rising edge
//   rst_n           in   1   asynchronous, active-low reset
//   redirect_valid  in   1   branch/jump taken this cycle
//   redirect_pc     in   32  new byte PC; bits [1:0] ignored (treated as 0)
//   inst_ready      in   1   decode accepts the head instruction
//   inst_valid      out  1   head instruction valid
//   inst_data       out  32  head instruction word
//   inst_pc         out  32  byte PC of head instruction
//   mem_addr        out  16  SPRAM word address = fetch_pc[17:2]; bit 15/14 select bank
//   mem_chip_sel    out  1   read request this cycle (wren is tied 0 outside this block)
//   mem_standby     out  1   SPRAM standby request
//   mem_rdata       in   32  SPRAM read data, valid the cycle after mem_chip_sel
// BEHAVIOUR
//   Reset (async): fetch_pc=RESET_PC, FIFO empty, inflight=0, drop=0, idle_cnt=0, state=RUN.
//     Outputs: inst_valid=0, inst_data=0, inst_pc=0, mem_chip_sel=0, mem_addr=0, mem_standby=0.
//   Issue cycle N: state=RUN, no redirect, and count+inflight < DEPTH.
//     Pops in cycle N are not credited.
//     On issue: mem_chip_sel=1, mem_addr=fetch_pc[17:2], fetch_pc+=4 (wraps mod 2^32).
//     Also sets inflight=1 and records the issued pc.
//     mem_addr is pc[17:2], so it wraps within 256 KB. When not issuing: chip_sel=0, mem_addr holds.
//   Capture cycle N+1: if inflight and !drop, push {pc, mem_rdata}. inflight clears unless reissued.
//     Credit rule guarantees a push never hits a full FIFO.
//   Output handshake: inst_valid = !empty and not a redirect cycle. inst_data/inst_pc = head.
//     Pop on inst_valid & inst_ready. Head stays stable while inst_ready=0.
//     Push and pop in the same cycle: both occur, count unchanged. Steady state gives 1 instr/cycle.
//   Redirect (highest priority, any state): in that cycle the FIFO is flushed, inst_valid=0 and no pop.
//     No issue that cycle. fetch_pc<=redirect_pc&~3. If inflight, drop=1 so next-cycle data is discarded.
//     Sets state=RUN, mem_standby=0, idle_cnt=0.
//     First redirected instruction: issue at R+1, inst_valid at R+2.
//   Back-to-back redirects: the last one wins; each flushes.
//   States:
//     RUN:
//       idle_cnt++ (saturating) on every non-issue cycle; reset to 0 on issue.
//       When idle_cnt reaches IDLE_LIMIT -> STANDBY with mem_standby=1.
//     STANDBY:
//       mem_standby=1, no issue.
//       Leave when a pop occurs (credit frees) or on redirect.
//       Next cycle: mem_standby=0 -> WAKE.
//     WAKE:
//       One cycle, no issue -> RUN, idle_cnt=0.
//       A redirect in WAKE goes to RUN directly (per the redirect rule).
//   The FIFO keeps draining to decode in every state.
//   Reset mid-operation: all state cleared asynchronously. An inflight SPRAM read is ignored.
// TESTING
//   1. Reset, RESET_PC=0, inst_ready=1, memory word k = k:
//      chip_sel first at cycle 1 with addr 0, inst_valid at cycle 2.
//      Then 1 instr/cycle, pc 0,4,8..., data 0,1,2...
//   2. inst_ready=0 from start: exactly DEPTH=4 issues (addr 0..3), FIFO full, no 5th chip_sel.
//      mem_standby rises IDLE_LIMIT=16 cycles after the last issue.
//   3. From (2) assert inst_ready=1: pop at once, standby drops the next cycle, WAKE lasts 1 cycle.
//      Then issue resumes at addr 4. Head pc sequence 0,4,8,12,16 with no gap in data order.
//   4. Redirect to 0x0001_0000 while one read is inflight and FIFO holds 2 entries:
//      stale data never appears at the output.
//      Next chip_sel has addr 0x4000 (bank 1); first valid pc=0x10000 two cycles later.
//   5. Redirect to 0x0003_FFFC: addr 0xFFFF, then pc 0x40000 with addr 0x0000 (wrap).
//      Redirect pc 0x103: fetch at pc 0x100.
//   6. Assert rst_n low mid-stream with FIFO non-empty and inflight=1:
//      inst_valid drops immediately (async) and stays 0 in the cycle after release.
//      Fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_prefetch.sv
// -----------------------------------------------------------------------------
// instr_fetch_prefetch
//
// Fetch stage between decode and the two-bank cascaded instruction SPRAM.
// It issues sequential word reads, absorbs the SPRAM's one-cycle read latency
// and buffers the returned words in a small FIFO that decode drains through a
// valid/ready handshake. A redirect flushes everything and restarts fetch at
// the new PC. After a long stretch without issuing a read, the SPRAM is put
// into standby.
//
// Handshake toward decode: inst_valid is asserted whenever the FIFO head holds
// an instruction (and no redirect is in progress). A transfer happens in every
// cycle where inst_valid and inst_ready are both high. While inst_ready is low
// the head (inst_valid, inst_data, inst_pc) stays stable.
//
// Ports
//   clk             in   1   clock, rising edge
//   rst_n           in   1   asynchronous active-low reset
//   redirect_valid  in   1   branch/jump taken this cycle
//   redirect_pc     in   32  new byte PC (bits [1:0] ignored)
//   inst_ready      in   1   decode accepts the head instruction
//   inst_valid      out  1   head instruction valid
//   inst_data       out  32  head instruction word
//   inst_pc         out  32  byte PC of the head instruction
//   mem_addr        out  16  SPRAM word address (fetch_pc[17:2])
//   mem_chip_sel    out  1   read request this cycle
//   mem_standby     out  1   SPRAM standby request
//   mem_rdata       in   32  SPRAM read data, valid the cycle after chip select
// -----------------------------------------------------------------------------
module instr_fetch_prefetch #(
  parameter int          DEPTH      = 4,
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          IDLE_LIMIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        inst_ready,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic [15:0] mem_addr,
  output logic        mem_chip_sel,
  output logic        mem_standby,
  input  logic [31:0] mem_rdata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int IW = $clog2(IDLE_LIMIT + 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_STANDBY = 2'd1,
    ST_WAKE    = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [IW-1:0]   idle_cnt, idle_next;

  logic [31:0]     fetch_pc;
  logic [31:0]     inflight_pc;
  logic            inflight;
  logic [15:0]     addr_q;

  logic [31:0]     fifo_data [DEPTH];
  logic [31:0]     fifo_pc   [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;

  logic            empty;
  logic            pop;
  logic            push;
  logic            credit_ok;
  logic            issue;

  // ---------------------------------------------------------------------------
  // Datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    empty      = (count == '0);
    inst_valid = !empty && !redirect_valid;
    pop        = inst_valid && inst_ready;
    // The word returning this cycle belongs to the old path when a redirect
    // is taken, so it is discarded together with the flushed FIFO contents.
    push       = inflight && !redirect_valid;
    // Credit counts the stored entries plus the read still in flight; a pop
    // this cycle is deliberately not credited, so a capture never finds the
    // FIFO full.
    credit_ok  = (count + CW'(inflight)) < CW'(DEPTH);
    // rst_n gating keeps the request low while reset is held.
    issue      = rst_n && (state == ST_RUN) && !redirect_valid && credit_ok;

    mem_chip_sel = issue;
    mem_addr     = issue ? fetch_pc[17:2] : addr_q;
    inst_data    = fifo_data[rd_ptr];
    inst_pc      = fifo_pc[rd_ptr];
  end

  // ---------------------------------------------------------------------------
  // Standby FSM: next state and idle counter
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state;
    idle_next   = idle_cnt;
    mem_standby = (state == ST_STANDBY);

    if (redirect_valid) begin
      state_next = ST_RUN;
      idle_next  = '0;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (issue) begin
            idle_next = '0;
          end else begin
            if (idle_cnt != IW'(IDLE_LIMIT)) begin
              idle_next = idle_cnt + IW'(1);
            end
            // This non-issue cycle is the IDLE_LIMIT-th in a row.
            if (idle_cnt >= IW'(IDLE_LIMIT - 1)) begin
              state_next = ST_STANDBY;
            end
          end
        end
        ST_STANDBY: begin
          if (pop) begin
            state_next = ST_WAKE;
          end
        end
        ST_WAKE: begin
          state_next = ST_RUN;
          idle_next  = '0;
        end
        default: begin
          state_next = ST_RUN;
          idle_next  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      idle_cnt <= '0;
    end else begin
      state    <= state_next;
      idle_cnt <= idle_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch PC, in-flight read tracking and held SPRAM address
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      addr_q      <= '0;
    end else begin
      inflight <= issue;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc & ~32'h3;
      end else if (issue) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (issue) begin
        inflight_pc <= fetch_pc;
        addr_q      <= fetch_pc[17:2];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Prefetch FIFO
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_pc[i]   <= '0;
      end
    end else if (redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= mem_rdata;
        fifo_pc[wr_ptr]   <= inflight_pc;
        wr_ptr            <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_prefetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_prefetch
//
// Directed bench for instr_fetch_prefetch (DEPTH=4, RESET_PC=0, IDLE_LIMIT=16).
// The SPRAM model returns word k at word address k one cycle after the chip
// select. Inputs are driven and outputs sampled 1 time unit after the falling
// edge. "Interval i" below is the i-th clock period after reset release; a
// read requested in interval i is captured at the end of interval i+1 and is
// visible at the FIFO head in interval i+2.
// -----------------------------------------------------------------------------
module tb_instr_fetch_prefetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_ready = 1'b0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [15:0] mem_addr;
  logic        mem_chip_sel;
  logic        mem_standby;
  logic [31:0] mem_rdata = 32'hDEAD_BEEF;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];

  instr_fetch_prefetch #(
    .DEPTH(4),
    .RESET_PC(32'h0),
    .IDLE_LIMIT(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .inst_ready(inst_ready),
    .inst_valid(inst_valid),
    .inst_data(inst_data),
    .inst_pc(inst_pc),
    .mem_addr(mem_addr),
    .mem_chip_sel(mem_chip_sel),
    .mem_standby(mem_standby),
    .mem_rdata(mem_rdata)
  );

  // Clock and SPRAM model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_chip_sel) mem_rdata <= {16'h0, mem_addr};
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  // Returns positioned in interval 0 after release, just past the sample point.
  task automatic apply_reset(input logic ready);
    @(negedge clk);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    inst_ready     = ready;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    inst_ready = 1'b1;
    #1;
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid); end
    n_checks++; if (inst_data !== 32'h0) begin n_fail++; $display("FAIL reset_inst_data: got %h want 0", inst_data); end
    n_checks++; if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL reset_inst_pc: got %h want 0", inst_pc); end
    n_checks++; if (mem_chip_sel !== 1'b0) begin n_fail++; $display("FAIL reset_chip_sel: got %b want 0", mem_chip_sel); end
    n_checks++; if (mem_addr !== 16'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    n_checks++; if (mem_standby !== 1'b0) begin n_fail++; $display("FAIL reset_standby: got %b want 0", mem_standby); end
  endtask

  task automatic test_stream();
    logic [31:0] e;
    apply_reset(1'b1);
    n_checks++; if (mem_chip_sel !== 1'b1 || mem_addr !== 16'h0) begin n_fail++; $display("FAIL stream_first_issue: got cs=%b addr=%h want cs=1 addr=0", mem_chip_sel, mem_addr); end
    next_cycle();
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL stream_latency: got valid=%b want 0", inst_valid); end
    n_checks++; if (mem_chip_sel !== 1'b1 || mem_addr !== 16'h1) begin n_fail++; $display("FAIL stream_second_issue: got cs=%b addr=%h want cs=1 addr=1", mem_chip_sel, mem_addr); end
    for (int k = 0; k < 6; k++) exp_q.push_back(32'(k));
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      e = exp_q.pop_front();
      n_checks++;
      if (inst_valid !== 1'b1 || inst_pc !== (e << 2) || inst_data !== e) begin
        n_fail++;
        $display("FAIL stream_word%0d: got v=%b pc=%h d=%h want v=1 pc=%h d=%h", k, inst_valid, inst_pc, inst_data, e << 2, e);
      end
    end
  endtask

  // Decode stalled from reset, then released out of standby.
  task automatic test_stall_standby_wake();
    int          issues;
    int          last_issue;
    int          first_sb;
    logic [15:0] addrs[$];
    logic        exp_cs [5];
    logic [15:0] exp_ad [5];
    issues     = 0;
    last_issue = -1;
    first_sb   = -1;
    apply_reset(1'b0);
    for (int i = 0; i <= 30; i++) begin
      if (i > 0) next_cycle();
      if (mem_chip_sel === 1'b1) begin
        issues++;
        addrs.push_back(mem_addr);
        last_issue = i;
      end
      if (mem_standby === 1'b1 && first_sb < 0) first_sb = i;
    end
    n_checks++; if (issues !== 4) begin n_fail++; $display("FAIL stall_issue_count: got %0d want 4", issues); end
    for (int j = 0; j < addrs.size(); j++) begin
      n_checks++; if (addrs[j] !== 16'(j)) begin n_fail++; $display("FAIL stall_addr%0d: got %h want %h", j, addrs[j], j); end
    end
    n_checks++; if (last_issue !== 3) begin n_fail++; $display("FAIL stall_last_issue: got %0d want 3", last_issue); end
    n_checks++; if (first_sb !== 20) begin n_fail++; $display("FAIL stall_standby_rise: got %0d want 20", first_sb); end
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin n_fail++; $display("FAIL stall_head_hold: got v=%b pc=%h want v=1 pc=0", inst_valid, inst_pc); end

    // Interval 30: release decode; the head pops at once, still in standby.
    inst_ready = 1'b1;
    #1;
    n_checks++; if (inst_valid !== 1'b1 || mem_standby !== 1'b1 || mem_chip_sel !== 1'b0) begin n_fail++; $display("FAIL wake_pop: got v=%b sb=%b cs=%b want 1 1 0", inst_valid, mem_standby, mem_chip_sel); end
    // Intervals 31..35: WAKE (no issue), then issue resumes at word 4.
    exp_cs = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_ad = '{16'h0, 16'h4, 16'h5, 16'h6, 16'h7};
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      n_checks++; if (mem_standby !== 1'b0) begin n_fail++; $display("FAIL wake_standby%0d: got %b want 0", k, mem_standby); end
      n_checks++;
      if (mem_chip_sel !== exp_cs[k] || (exp_cs[k] && mem_addr !== exp_ad[k])) begin
        n_fail++;
        $display("FAIL wake_issue%0d: got cs=%b addr=%h want cs=%b addr=%h", k, mem_chip_sel, mem_addr, exp_cs[k], exp_ad[k]);
      end
      n_checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'((k + 1) * 4) || inst_data !== 32'(k + 1)) begin
        n_fail++;
        $display("FAIL wake_head%0d: got v=%b pc=%h d=%h want v=1 pc=%h d=%h", k, inst_valid, inst_pc, inst_data, (k + 1) * 4, k + 1);
      end
    end
  endtask

  // Redirect while the FIFO holds two words and a third read is in flight.
  task automatic test_redirect_flush();
    apply_reset(1'b0);
    repeat (3) next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0001_0000;
    #1;
    n_checks++; if (inst_valid !== 1'b0 || mem_chip_sel !== 1'b0) begin n_fail++; $display("FAIL flush_redirect_cycle: got v=%b cs=%b want 0 0", inst_valid, mem_chip_sel); end
    next_cycle();
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    #1;
    n_checks++; if (mem_chip_sel !== 1'b1 || mem_addr !== 16'h4000 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL flush_bank1_issue: got cs=%b addr=%h v=%b want 1 4000 0", mem_chip_sel, mem_addr, inst_valid); end
    next_cycle();
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL flush_stale: got v=%b pc=%h want v=0", inst_valid, inst_pc); end
    next_cycle();
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0001_0000 || inst_data !== 32'h4000) begin n_fail++; $display("FAIL flush_first: got v=%b pc=%h d=%h want 1 10000 4000", inst_valid, inst_pc, inst_data); end
    next_cycle();
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0001_0004 || inst_data !== 32'h4001) begin n_fail++; $display("FAIL flush_second: got v=%b pc=%h d=%h want 1 10004 4001", inst_valid, inst_pc, inst_data); end
  endtask

  task automatic test_redirect_wrap();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0003_FFFC;
    next_cycle();
    redirect_valid = 1'b0;
    #1;
    n_checks++; if (mem_chip_sel !== 1'b1 || mem_addr !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_top: got cs=%b addr=%h want 1 ffff", mem_chip_sel, mem_addr); end
    next_cycle();
    n_checks++; if (mem_chip_sel !== 1'b1 || mem_addr !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero: got cs=%b addr=%h want 1 0000", mem_chip_sel, mem_addr); end
    next_cycle();
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0003_FFFC || inst_data !== 32'hFFFF) begin n_fail++; $display("FAIL wrap_head0: got v=%b pc=%h d=%h want 1 3fffc ffff", inst_valid, inst_pc, inst_data); end
    next_cycle();
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0004_0000 || inst_data !== 32'h0) begin n_fail++; $display("FAIL wrap_head1: got v=%b pc=%h d=%h want 1 40000 0", inst_valid, inst_pc, inst_data); end

    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    next_cycle();
    redirect_valid = 1'b0;
    #1;
    n_checks++; if (mem_chip_sel !== 1'b1 || mem_addr !== 16'h0040) begin n_fail++; $display("FAIL align_addr: got cs=%b addr=%h want 1 0040", mem_chip_sel, mem_addr); end
    repeat (2) next_cycle();
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst_data !== 32'h40) begin n_fail++; $display("FAIL align_head: got v=%b pc=%h d=%h want 1 100 40", inst_valid, inst_pc, inst_data); end
  endtask

  task automatic test_back_to_back();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    next_cycle();
    redirect_pc = 32'h300;
    #1;
    n_checks++; if (mem_chip_sel !== 1'b0 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_second: got cs=%b v=%b want 0 0", mem_chip_sel, inst_valid); end
    next_cycle();
    redirect_valid = 1'b0;
    #1;
    n_checks++; if (mem_chip_sel !== 1'b1 || mem_addr !== 16'h00C0) begin n_fail++; $display("FAIL b2b_issue: got cs=%b addr=%h want 1 00c0", mem_chip_sel, mem_addr); end
    next_cycle();
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_gap: got v=%b pc=%h want v=0", inst_valid, inst_pc); end
    next_cycle();
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h300 || inst_data !== 32'hC0) begin n_fail++; $display("FAIL b2b_head: got v=%b pc=%h d=%h want 1 300 c0", inst_valid, inst_pc, inst_data); end
  endtask

  task automatic test_reset_midstream();
    next_cycle();
    n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got v=%b want 1", inst_valid); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (inst_valid !== 1'b0 || mem_chip_sel !== 1'b0 || inst_pc !== 32'h0) begin n_fail++; $display("FAIL mid_async: got v=%b cs=%b pc=%h want 0 0 0", inst_valid, mem_chip_sel, inst_pc); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++; if (inst_valid !== 1'b0 || mem_chip_sel !== 1'b1 || mem_addr !== 16'h0) begin n_fail++; $display("FAIL mid_restart: got v=%b cs=%b addr=%h want 0 1 0", inst_valid, mem_chip_sel, mem_addr); end
    next_cycle();
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL mid_after_release: got v=%b want 0", inst_valid); end
    next_cycle();
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== 32'h0) begin n_fail++; $display("FAIL mid_head0: got v=%b pc=%h d=%h want 1 0 0", inst_valid, inst_pc, inst_data); end
    next_cycle();
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h4 || inst_data !== 32'h1) begin n_fail++; $display("FAIL mid_head1: got v=%b pc=%h d=%h want 1 4 1", inst_valid, inst_pc, inst_data); end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_stream();
    test_stall_standby_wake();
    test_redirect_flush();
    test_redirect_wrap();
    test_back_to_back();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
